// File: rtl/conv_window_sched.sv
// conv_window_sched
//   Walks every output position of one feature map in raster order, issuing
//   window-origin requests to the window buffer. A credit counter caps the
//   number of requests still waiting for a calculator result. Each result
//   strobe becomes one output-memory write at the next sequential address,
//   and a one-cycle done pulse marks the end of the layer.
//
//   Valid/ready: a request transfers on a cycle where o_win_valid and
//   i_win_ready are both 1; o_win_row/o_win_col hold steady while
//   o_win_valid=1 and i_win_ready=0. i_calc_valid returns one strobe per
//   accepted request, in order, with no back-pressure.
//
// Optional feature macro: CONV_SCHED_PERF_EN adds o_perf_cycles and
//   o_perf_stalls (RUN-entry..DONE cycle count and RUN stall count).
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               layer start (used only in IDLE)
//   o_win_valid/i_win_ready, o_win_row/o_win_col   window request
//   i_calc_valid          calculator result strobe
//   o_out_wr_en/o_out_addr output-memory write
//   o_busy, o_done, o_err status (err is sticky until the next start)
//   o_state               FSM state for debug (0 IDLE,1 RUN,2 DRAIN,3 DONE)
module conv_window_sched #(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int FILTER_SIZE = 5,
  parameter int STRIDE      = 1,
  parameter int MAX_OUT     = 4,
  parameter int ADDR_BITS   = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic                 o_win_valid,
  input  logic                 i_win_ready,
  output logic [7:0]           o_win_row,
  output logic [7:0]           o_win_col,
  input  logic                 i_calc_valid,
  output logic                 o_out_wr_en,
  output logic [ADDR_BITS-1:0] o_out_addr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
`ifdef CONV_SCHED_PERF_EN
  output logic [31:0]          o_perf_cycles,
  output logic [31:0]          o_perf_stalls,
`endif
  output logic [1:0]           o_state
);

  localparam int OUT_W = (IMG_W - FILTER_SIZE) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - FILTER_SIZE) / STRIDE + 1;
  localparam int N_OUT = OUT_W * OUT_H;
  localparam int CNT_W = ADDR_BITS + 1;

  localparam logic [CNT_W-1:0] N_OUT_C   = CNT_W'(N_OUT);
  localparam logic [3:0]       MAX_OUT_C = 4'(MAX_OUT);
  localparam logic [7:0]       COL_LAST  = 8'((OUT_W - 1) * STRIDE);
  localparam logic [7:0]       STEP      = 8'(STRIDE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  logic [7:0]           r_row;
  logic [7:0]           r_col;
  logic [CNT_W-1:0]     r_issued;
  logic [CNT_W-1:0]     r_written;
  logic [3:0]           r_outst;
  logic                 r_win_valid;
  logic                 r_wr_en;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic             w_hs;
  logic             w_calc_ok;
  logic [CNT_W-1:0] w_issued_nxt;
  logic [3:0]       w_outst_nxt;

  always_comb begin
    w_hs         = (r_state == S_RUN) && r_win_valid && i_win_ready;
    // A result only counts when something is actually in flight.
    w_calc_ok    = i_calc_valid && (r_outst != 4'd0) &&
                   ((r_state == S_RUN) || (r_state == S_DRAIN));
    w_issued_nxt = r_issued + CNT_W'(w_hs);
    w_outst_nxt  = r_outst + {3'b000, w_hs} - {3'b000, w_calc_ok};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_issued    <= '0;
      r_written   <= '0;
      r_outst     <= '0;
      r_win_valid <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      if (i_calc_valid && (r_outst == 4'd0)) r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_row       <= '0;
          r_col       <= '0;
          r_issued    <= '0;
          r_written   <= '0;
          r_outst     <= '0;
          r_win_valid <= 1'b0;
          if (i_start) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_win_valid <= 1'b1;
            r_err       <= 1'b0;
          end
        end

        S_RUN, S_DRAIN: begin
          if (w_calc_ok) begin
            r_wr_en   <= 1'b1;
            r_addr    <= r_written[ADDR_BITS-1:0];
            r_written <= r_written + CNT_W'(1);
          end
          r_issued <= w_issued_nxt;
          r_outst  <= w_outst_nxt;
          if (w_hs) begin
            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + STEP;
            end else begin
              r_col <= r_col + STEP;
            end
          end
          if (r_state == S_RUN) begin
            if (w_issued_nxt == N_OUT_C) begin
              r_state     <= S_DRAIN;
              r_win_valid <= 1'b0;
            end else begin
              r_win_valid <= (w_outst_nxt < MAX_OUT_C);
            end
          end else if (r_written == N_OUT_C) begin
            // Last write strobe is on the outputs this cycle.
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (r_state != S_IDLE) r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == S_RUN) && r_win_valid && !i_win_ready)
        r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign o_perf_cycles = r_perf_cycles;
  assign o_perf_stalls = r_perf_stalls;
`endif

  assign o_win_valid = r_win_valid;
  assign o_win_row   = r_row;
  assign o_win_col   = r_col;
  assign o_out_wr_en = r_wr_en;
  assign o_out_addr  = r_addr;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_state     = r_state;

endmodule

// File: tb/tb_conv_window_sched.sv
// Bench for conv_window_sched. Two instances share all inputs:
//   cfg 0: 6x6 image, 3x3 kernel, stride 1, MAX_OUT 4 -> 4x4 outputs
//   cfg 1: 7x7 image, 3x3 kernel, stride 2, MAX_OUT 2 -> 3x3 outputs
// Checks are made against the selected instance; every scenario begins
// from reset or from IDLE so the other instance's state never matters.
module tb_conv_window_sched;
  localparam int AB = 10;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic win_ready;
  logic calc_valid;

  logic          win_valid_v [2];
  logic [7:0]    win_row_v   [2];
  logic [7:0]    win_col_v   [2];
  logic          out_wr_en_v [2];
  logic [AB-1:0] out_addr_v  [2];
  logic          busy_v      [2];
  logic          done_v      [2];
  logic          err_v       [2];
  logic [1:0]    state_v     [2];
`ifdef CONV_SCHED_PERF_EN
  logic [31:0]   perf_cycles_v [2];
  logic [31:0]   perf_stalls_v [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Selected configuration, derived from the image/kernel geometry.
  int sel, img, stride, ow, oh, n_out, max_out;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    conv_window_sched #(
      .IMG_W      ((g == 0) ? 6 : 7),
      .IMG_H      ((g == 0) ? 6 : 7),
      .FILTER_SIZE(3),
      .STRIDE     ((g == 0) ? 1 : 2),
      .MAX_OUT    ((g == 0) ? 4 : 2),
      .ADDR_BITS  (AB)
    ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .o_win_valid  (win_valid_v[g]),
      .i_win_ready  (win_ready),
      .o_win_row    (win_row_v[g]),
      .o_win_col    (win_col_v[g]),
      .i_calc_valid (calc_valid),
      .o_out_wr_en  (out_wr_en_v[g]),
      .o_out_addr   (out_addr_v[g]),
      .o_busy       (busy_v[g]),
      .o_done       (done_v[g]),
      .o_err        (err_v[g]),
`ifdef CONV_SCHED_PERF_EN
      .o_perf_cycles(perf_cycles_v[g]),
      .o_perf_stalls(perf_stalls_v[g]),
`endif
      .o_state      (state_v[g])
    );
  end

  task automatic set_cfg(input int s);
    sel     = s;
    img     = (s == 0) ? 6 : 7;
    stride  = (s == 0) ? 1 : 2;
    max_out = (s == 0) ? 4 : 2;
    ow      = (img - 3) / stride + 1;
    oh      = (img - 3) / stride + 1;
    n_out   = ow * oh;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; win_ready = 1'b0; calc_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one layer from IDLE. The model is the raster list of window origins,
  // the ordered list of write addresses, and issue/return counts for credits.
  task automatic run_layer(input int ready_pct, input int lat_min, input int lat_max,
                           input int abort_writes, input bit spurious);
    int exp_r[$];
    int exp_c[$];
    logic [AB-1:0] exp_q[$];
    int calc_due[$];
    int cyc, hs_cnt, calc_cnt, stalls, last_wr, done_cnt, done_cyc, writes, due, er, ec;
    bit prev_stall, finished;
    logic wv, exp_wv, exp_busy;
    logic [7:0] prev_row, prev_col;
    logic [AB-1:0] ea;
    cyc = 0; hs_cnt = 0; calc_cnt = 0; stalls = 0; last_wr = -10;
    done_cnt = 0; done_cyc = -1; writes = 0; prev_stall = 1'b0; finished = 1'b0;
    prev_row = '0; prev_col = '0;
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++) begin
        exp_r.push_back(r * stride);
        exp_c.push_back(c * stride);
      end
    for (int a = 0; a < n_out; a++) exp_q.push_back(AB'(a));

    @(negedge clk);
    start = 1'b1; win_ready = 1'b0; calc_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy_v[sel] !== 1'b1) begin
      n_fail++; $display("FAIL start_busy: got %b expected 1", busy_v[sel]);
    end

    while (!finished && cyc < 3000) begin
      wv = win_valid_v[sel];
      if (out_wr_en_v[sel] === 1'b1) begin
        writes++; last_wr = cyc; n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL extra_write: got addr %0d expected no write", out_addr_v[sel]);
        end else begin
          ea = exp_q.pop_front();
          if (out_addr_v[sel] !== ea) begin
            n_fail++; $display("FAIL write_addr: got %0d expected %0d", out_addr_v[sel], ea);
          end
        end
      end
      if (abort_writes > 0 && writes >= abort_writes) begin
        finished = 1'b1;
      end else begin
        exp_wv = (hs_cnt < n_out) && (hs_cnt - calc_cnt < max_out);
        n_tests++;
        if (wv !== exp_wv) begin
          n_fail++; $display("FAIL win_valid: cycle %0d got %b expected %b", cyc, wv, exp_wv);
        end
        if (prev_stall) begin
          n_tests++;
          if (!(wv === 1'b1 && win_row_v[sel] === prev_row && win_col_v[sel] === prev_col)) begin
            n_fail++;
            $display("FAIL stall_hold: got v=%b (%0d,%0d) expected v=1 (%0d,%0d)",
                     wv, win_row_v[sel], win_col_v[sel], prev_row, prev_col);
          end
        end
        exp_busy = (done_cnt == 0) && (done_v[sel] !== 1'b1);
        n_tests++;
        if (busy_v[sel] !== exp_busy) begin
          n_fail++; $display("FAIL busy: cycle %0d got %b expected %b", cyc, busy_v[sel], exp_busy);
        end
        if (done_v[sel] === 1'b1) begin
          n_tests++;
          if (cyc != last_wr + 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_timing: got done at %0d (%0d writes left) expected %0d (0 left)",
                     cyc, exp_q.size(), last_wr + 1);
          end
          done_cnt++; done_cyc = cyc;
        end
        if (done_cnt > 0 && cyc >= done_cyc + 3) finished = 1'b1;

        win_ready = (int'($urandom_range(0, 99)) < ready_pct);
        start = spurious && (done_cnt == 0) && (busy_v[sel] === 1'b1) &&
                ($urandom_range(0, 15) == 0);
        if (wv === 1'b1 && win_ready) begin
          n_tests++;
          if (exp_r.size() == 0) begin
            n_fail++; $display("FAIL extra_request: got (%0d,%0d) expected none",
                               win_row_v[sel], win_col_v[sel]);
          end else begin
            er = exp_r.pop_front(); ec = exp_c.pop_front();
            if (win_row_v[sel] !== 8'(er) || win_col_v[sel] !== 8'(ec)) begin
              n_fail++; $display("FAIL request: got (%0d,%0d) expected (%0d,%0d)",
                                 win_row_v[sel], win_col_v[sel], er, ec);
            end
          end
          hs_cnt++;
          due = cyc + int'($urandom_range(lat_min, lat_max));
          if (calc_due.size() > 0 && due <= calc_due[$]) due = calc_due[$] + 1;
          calc_due.push_back(due);
        end
        calc_valid = 1'b0;
        if (calc_due.size() > 0 && calc_due[0] == cyc) begin
          void'(calc_due.pop_front());
          calc_valid = 1'b1;
          calc_cnt++;
        end
        prev_stall = (wv === 1'b1) && !win_ready;
        if (prev_stall) stalls++;
        prev_row = win_row_v[sel];
        prev_col = win_col_v[sel];
        @(negedge clk);
        cyc++;
      end
    end

    if (!finished) begin
      n_tests++; n_fail++;
      $display("FAIL layer_timeout: got no done after %0d cycles expected done", cyc);
    end else if (abort_writes == 0) begin
      n_tests++;
      if (done_cnt != 1) begin
        n_fail++; $display("FAIL done_count: got %0d expected 1", done_cnt);
      end
      n_tests++;
      if (exp_r.size() != 0 || exp_q.size() != 0) begin
        n_fail++; $display("FAIL leftover: got %0d requests %0d writes missing expected 0 0",
                           exp_r.size(), exp_q.size());
      end
`ifdef CONV_SCHED_PERF_EN
      n_tests++;
      if (perf_cycles_v[sel] !== 32'(done_cyc + 1)) begin
        n_fail++; $display("FAIL perf_cycles: got %0d expected %0d", perf_cycles_v[sel], done_cyc + 1);
      end
      n_tests++;
      if (perf_stalls_v[sel] !== 32'(stalls)) begin
        n_fail++; $display("FAIL perf_stalls: got %0d expected %0d", perf_stalls_v[sel], stalls);
      end
`endif
    end
    win_ready = 1'b0; calc_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    set_cfg(0);
    do_reset();
    n_tests++; if (win_valid_v[sel] !== 1'b0) begin n_fail++; $display("FAIL reset_win_valid: got %b expected 0", win_valid_v[sel]); end
    n_tests++; if (win_row_v[sel] !== 8'd0) begin n_fail++; $display("FAIL reset_win_row: got %0d expected 0", win_row_v[sel]); end
    n_tests++; if (win_col_v[sel] !== 8'd0) begin n_fail++; $display("FAIL reset_win_col: got %0d expected 0", win_col_v[sel]); end
    n_tests++; if (out_wr_en_v[sel] !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", out_wr_en_v[sel]); end
    n_tests++; if (out_addr_v[sel] !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", out_addr_v[sel]); end
    n_tests++; if (busy_v[sel] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_v[sel]); end
    n_tests++; if (done_v[sel] !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_v[sel]); end
    n_tests++; if (err_v[sel] !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_v[sel]); end
    n_tests++; if (state_v[sel] !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_v[sel]); end
  endtask

  task automatic test_stride1();
    set_cfg(0); do_reset();
    run_layer(100, 2, 2, 0, 1'b0);
  endtask

  task automatic test_stride2();
    set_cfg(1); do_reset();
    run_layer(100, 2, 2, 0, 1'b0);
  endtask

  task automatic test_credit();
    int hs;
    set_cfg(1); do_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; win_ready = 1'b1; calc_valid = 1'b0;
    hs = 0;
    repeat (10) begin
      if (win_valid_v[sel] === 1'b1) hs++;
      @(negedge clk);
    end
    n_tests++; if (hs != max_out) begin n_fail++; $display("FAIL credit_requests: got %0d expected %0d", hs, max_out); end
    n_tests++; if (win_valid_v[sel] !== 1'b0) begin n_fail++; $display("FAIL credit_block: got %b expected 0", win_valid_v[sel]); end
    calc_valid = 1'b1;
    @(negedge clk); calc_valid = 1'b0;
    n_tests++; if (out_wr_en_v[sel] !== 1'b1 || out_addr_v[sel] !== '0) begin
      n_fail++; $display("FAIL credit_write: got en=%b addr=%0d expected en=1 addr=0", out_wr_en_v[sel], out_addr_v[sel]);
    end
    n_tests++; if (win_valid_v[sel] !== 1'b1 || win_row_v[sel] !== 8'd0 || win_col_v[sel] !== 8'd4) begin
      n_fail++; $display("FAIL credit_resume: got v=%b (%0d,%0d) expected v=1 (0,4)", win_valid_v[sel], win_row_v[sel], win_col_v[sel]);
    end
    win_ready = 1'b0;
  endtask

  task automatic test_err_idle();
    set_cfg(0); do_reset();
    @(negedge clk); calc_valid = 1'b1;
    @(negedge clk); calc_valid = 1'b0;
    n_tests++; if (out_wr_en_v[sel] !== 1'b0) begin n_fail++; $display("FAIL err_no_write: got %b expected 0", out_wr_en_v[sel]); end
    n_tests++; if (err_v[sel] !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err_v[sel]); end
    repeat (3) @(negedge clk);
    n_tests++; if (err_v[sel] !== 1'b1 || out_wr_en_v[sel] !== 1'b0) begin
      n_fail++; $display("FAIL err_sticky: got err=%b en=%b expected err=1 en=0", err_v[sel], out_wr_en_v[sel]);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_tests++; if (err_v[sel] !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", err_v[sel]); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic [30:0] outs;
    bit bad;
    set_cfg(0); do_reset();
    run_layer(100, 2, 2, 5, 1'b0);
    win_ready = 1'b0; calc_valid = 1'b0; start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    outs = {win_valid_v[sel], win_row_v[sel], win_col_v[sel], out_wr_en_v[sel],
            out_addr_v[sel], busy_v[sel], done_v[sel], err_v[sel]};
    n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h expected 0", outs); end
    @(negedge clk); rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[sel] !== 1'b0 || out_wr_en_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0) bad = 1'b1;
    end
    n_tests++; if (bad) begin n_fail++; $display("FAIL mid_reset_quiet: got activity expected none"); end
    run_layer(100, 2, 2, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      set_cfg(k % 2); do_reset();
      run_layer(60, 1, 6, 0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(0); do_reset();
    run_layer(80, 1, 4, 0, 1'b0);
    run_layer(100, 1, 3, 0, 1'b1);
    set_cfg(1); do_reset();
    run_layer(70, 1, 5, 0, 1'b0);
    run_layer(100, 2, 2, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; win_ready = 1'b0; calc_valid = 1'b0;
    test_reset();
    test_stride1();
    test_stride2();
    test_credit();
    test_err_idle();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
